// File: rtl/matrix_scan_ctrl.sv
// Double-buffered RGB LED matrix scan controller. Pixel writes land in the back
// buffer; the front buffer is column-scanned and swaps happen only at frame ends.
module matrix_scan_ctrl #(
    parameter int ROWS         = 8,
    parameter int COLS         = 12,
    parameter int ON_CYCLES    = 30,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [$clog2(COLS)-1:0] wr_col,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [2:0]              wr_rgb,
    input  logic                    swap_req,
    output logic                    swap_ack,
    output logic                    frame_start,
    output logic [ROWS-1:0]         led_r,
    output logic [ROWS-1:0]         led_g,
    output logic [ROWS-1:0]         led_b,
    output logic [COLS-1:0]         led_selc,
    output logic                    led_rst
);
    localparam int CW      = $clog2(COLS);
    localparam int RW      = $clog2(ROWS);
    localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CNTW    = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0]   COL_LAST   = CW'(COLS - 1);
    localparam logic [CW:0]     COL_LIMIT  = (CW + 1)'(COLS);
    localparam logic [RW:0]     ROW_LIMIT  = (RW + 1)'(ROWS);
    localparam logic [CNTW-1:0] ON_LAST    = CNTW'(ON_CYCLES - 1);
    localparam logic [CNTW-1:0] BLANK_LAST = CNTW'(BLANK_CYCLES - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   col_r, col_s;
    logic [CNTW-1:0] cnt_r, cnt_s;
    logic            front_r, front_s;
    logic            pending_r, pending_s;
    logic            ack_s;
    logic            fstart_s;
    logic [ROWS-1:0] led_r_s, led_g_s, led_b_s;
    logic [COLS-1:0] selc_s;
    logic            rst_s;
    logic            wr_fire_s;

    logic [2:0] mem_r [2][COLS][ROWS];

    // Out-of-range coordinates are accepted by the handshake but never stored.
    assign wr_fire_s = wr_valid & wr_ready
                       & ({1'b0, wr_col} < COL_LIMIT)
                       & ({1'b0, wr_row} < ROW_LIMIT);

    // Scan sequencing and swap bookkeeping
    always_comb begin
        state_s   = state_r;
        col_s     = col_r;
        cnt_s     = cnt_r + CNTW'(1);
        front_s   = front_r;
        pending_s = pending_r;
        ack_s     = 1'b0;
        fstart_s  = 1'b0;
        case (state_r)
            ST_BLANK: begin
                if (cnt_r == BLANK_LAST) begin
                    state_s  = ST_ON;
                    cnt_s    = '0;
                    fstart_s = (col_r == '0);
                end else begin
                    state_s = ST_BLANK;
                end
            end
            ST_ON: begin
                if (cnt_r == ON_LAST) begin
                    state_s = ST_BLANK;
                    cnt_s   = '0;
                    if (col_r == COL_LAST) begin
                        col_s = '0;
                        if (pending_r) begin
                            front_s   = ~front_r;
                            pending_s = 1'b0;
                            ack_s     = 1'b1;
                        end else begin
                            front_s = front_r;
                        end
                    end else begin
                        col_s = col_r + CW'(1);
                    end
                end else begin
                    state_s = ST_ON;
                end
            end
            default: begin
                state_s = ST_BLANK;
                col_s   = '0;
                cnt_s   = '0;
            end
        endcase
        // A request arriving while one is already pending is dropped.
        if (swap_req && !pending_r) begin
            pending_s = 1'b1;
        end else begin
            pending_s = pending_s;
        end
    end

    // Next values of the LED drive, taken from the state being entered
    always_comb begin
        led_r_s = '0;
        led_g_s = '0;
        led_b_s = '0;
        selc_s  = '1;
        rst_s   = 1'b1;
        if (state_s == ST_ON) begin
            rst_s         = 1'b0;
            selc_s[col_s] = 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                led_r_s[r] = mem_r[front_s][col_s][r][2];
                led_g_s[r] = mem_r[front_s][col_s][r][1];
                led_b_s[r] = mem_r[front_s][col_s][r][0];
            end
        end else begin
            rst_s = 1'b1;
        end
    end

    // Scan state, column, counter and buffer select registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_BLANK;
            col_r     <= '0;
            cnt_r     <= '0;
            front_r   <= 1'b0;
            pending_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            col_r     <= col_s;
            cnt_r     <= cnt_s;
            front_r   <= front_s;
            pending_r <= pending_s;
        end
    end

    // Frame buffers; writes only ever address the back buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < COLS; c++) begin
                    for (int r = 0; r < ROWS; r++) begin
                        mem_r[b][c][r] <= 3'b000;
                    end
                end
            end
        end else if (wr_fire_s) begin
            mem_r[~front_r][wr_col][wr_row] <= wr_rgb;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r       <= '0;
            led_g       <= '0;
            led_b       <= '0;
            led_selc    <= '1;
            led_rst     <= 1'b1;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
            wr_ready    <= 1'b1;
        end else begin
            led_r       <= led_r_s;
            led_g       <= led_g_s;
            led_b       <= led_b_s;
            led_selc    <= selc_s;
            led_rst     <= rst_s;
            swap_ack    <= ack_s;
            frame_start <= fstart_s;
            wr_ready    <= ~pending_s;
        end
    end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Self-checking bench for matrix_scan_ctrl: a frame-buffer model feeds an
// expected-display queue that is popped when the DUT lights a column.
module tb_matrix_scan_ctrl;
    localparam int ROWS  = 8;
    localparam int COLS  = 12;
    localparam int P     = 34;
    localparam int FRAME = 408;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [3:0]  wr_col = 4'd0;
    logic [2:0]  wr_row = 3'd0;
    logic [2:0]  wr_rgb = 3'd0;
    logic        swap_req = 1'b0;
    logic        swap_ack;
    logic        frame_start;
    logic [7:0]  led_r, led_g, led_b;
    logic [11:0] led_selc;
    logic        led_rst;

    int tests = 0;
    int fails = 0;
    int edge_n;

    logic [2:0]  mdl [2][COLS][ROWS];
    logic        mdl_front;
    logic [35:0] exp_q [$];
    logic [35:0] got, want;

    matrix_scan_ctrl dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_col(wr_col), .wr_row(wr_row), .wr_rgb(wr_rgb), .swap_req(swap_req),
        .swap_ack(swap_ack), .frame_start(frame_start), .led_r(led_r),
        .led_g(led_g), .led_b(led_b), .led_selc(led_selc), .led_rst(led_rst)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic mdl_clear();
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < COLS; c++)
                for (int r = 0; r < ROWS; r++)
                    mdl[b][c][r] = 3'b000;
        mdl_front = 1'b0;
        exp_q.delete();
    endtask

    task automatic push_exp(input int c);
        logic [11:0] s;
        logic [7:0]  r, g, b;
        s = 12'hFFF;
        s[c] = 1'b0;
        for (int rr = 0; rr < ROWS; rr++) begin
            r[rr] = mdl[mdl_front][c][rr][2];
            g[rr] = mdl[mdl_front][c][rr][1];
            b[rr] = mdl[mdl_front][c][rr][0];
        end
        exp_q.push_back({s, r, g, b});
    endtask

    task automatic goto(input int n);
        int guard;
        guard = 0;
        while (edge_n < n && guard < 20000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (edge_n != n) begin
            fails++;
            $display("FAIL goto edge reached %0d required %0d", edge_n, n);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_valid = 1'b0;
        swap_req = 1'b0;
        #1;
        mdl_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_write(input logic [3:0] c, input logic [2:0] r, input logic [2:0] rgb);
        int k;
        k = edge_n;
        wr_col = c; wr_row = r; wr_rgb = rgb; wr_valid = 1'b1;
        if (wr_ready === 1'b1 && c < COLS) mdl[~mdl_front][c][r] = rgb;
        goto(k + 1);
        wr_valid = 1'b0;
    endtask

    task automatic pulse_swap();
        int k;
        k = edge_n;
        swap_req = 1'b1;
        goto(k + 1);
        swap_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mdl_clear();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({led_selc, led_r, led_g, led_b, led_rst, swap_ack, frame_start, wr_ready} !==
            {12'hFFF, 24'h0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_hold selc=%h rgb=%h/%h/%h rst=%b ack=%b fs=%b rdy=%b required FFF/0/0/0/1/0/0/1",
                     led_selc, led_r, led_g, led_b, led_rst, swap_ack, frame_start, wr_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        goto(3);
        tests++;
        if (led_selc !== 12'hFFF || led_rst !== 1'b1) begin
            fails++; $display("FAIL blank_edge3 selc=%h rst=%b required FFF 1", led_selc, led_rst);
        end
        goto(4);
        push_exp(0);
        got = {led_selc, led_r, led_g, led_b}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL col0_edge4 got %h required %h", got, want); end
        tests++;
        if (led_rst !== 1'b0 || frame_start !== 1'b1) begin
            fails++; $display("FAIL fs_edge4 rst=%b fs=%b required 0 1", led_rst, frame_start);
        end
        goto(5);
        tests++;
        if (frame_start !== 1'b0) begin fails++; $display("FAIL fs_edge5 got %b required 0", frame_start); end
        goto(37);
        tests++;
        if (led_selc !== 12'hFFF || led_rst !== 1'b1) begin
            fails++; $display("FAIL blank_edge37 selc=%h rst=%b required FFF 1", led_selc, led_rst);
        end
        goto(38);
        push_exp(1);
        got = {led_selc, led_r, led_g, led_b}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL col1_edge38 got %h required %h", got, want); end
        goto(411);
        tests++;
        if (frame_start !== 1'b0) begin fails++; $display("FAIL fs_edge411 got %b required 0", frame_start); end
        goto(412);
        tests++;
        if (frame_start !== 1'b1 || led_selc !== 12'hFFE) begin
            fails++; $display("FAIL fs_edge412 fs=%b selc=%h required 1 FFE", frame_start, led_selc);
        end
    endtask

    task automatic test_write_swap();
        do_reset();
        goto(2);
        do_write(4'd3, 3'd5, 3'b100);
        goto(9);
        pulse_swap();
        tests++;
        if (wr_ready !== 1'b0) begin fails++; $display("FAIL ready_after_req got %b required 0", wr_ready); end
        goto(106);
        push_exp(3);
        got = {led_selc, led_r, led_g, led_b}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL col3_before_swap got %h required %h", got, want); end
        goto(407);
        tests++;
        if (wr_ready !== 1'b0 || swap_ack !== 1'b0) begin
            fails++; $display("FAIL pending_edge407 rdy=%b ack=%b required 0 0", wr_ready, swap_ack);
        end
        goto(408);
        tests++;
        if (wr_ready !== 1'b1 || swap_ack !== 1'b1) begin
            fails++; $display("FAIL swap_edge408 rdy=%b ack=%b required 1 1", wr_ready, swap_ack);
        end
        mdl_front = ~mdl_front;
        goto(409);
        tests++;
        if (swap_ack !== 1'b0) begin fails++; $display("FAIL ack_edge409 got %b required 0", swap_ack); end
        goto(106 + FRAME);
        push_exp(3);
        got = {led_selc, led_r, led_g, led_b}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL col3_after_swap got %h required %h", got, want); end
    endtask

    task automatic test_isolation();
        do_reset();
        goto(2);
        do_write(4'd0, 3'd0, 3'b111);
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < COLS; c++) begin
                goto(4 + c * P + f * FRAME);
                push_exp(c);
                got = {led_selc, led_r, led_g, led_b}; want = exp_q.pop_front(); tests++;
                if (got !== want) begin
                    fails++; $display("FAIL isolation f%0d c%0d got %h required %h", f, c, got, want);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        int early;
        do_reset();
        goto(2);
        pulse_swap();
        wr_col = 4'd2; wr_row = 3'd1; wr_rgb = 3'b010; wr_valid = 1'b1;
        early = 0;
        while (edge_n < 408) begin
            if (wr_ready !== 1'b0) early++;
            goto(edge_n + 1);
        end
        tests++;
        if (early !== 0) begin fails++; $display("FAIL backpressure ready_high_cycles %0d required 0", early); end
        tests++;
        if (swap_ack !== 1'b1 || wr_ready !== 1'b1) begin
            fails++; $display("FAIL bp_swap ack=%b rdy=%b required 1 1", swap_ack, wr_ready);
        end
        mdl_front = ~mdl_front;
        mdl[~mdl_front][2][1] = 3'b010;
        goto(409);
        wr_valid = 1'b0;
        goto(4 + 2 * P + FRAME);
        push_exp(2);
        got = {led_selc, led_r, led_g, led_b}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL bp_hidden got %h required %h", got, want); end
        goto(499);
        pulse_swap();
        goto(2 * FRAME);
        tests++;
        if (swap_ack !== 1'b1) begin fails++; $display("FAIL bp_second_swap got %b required 1", swap_ack); end
        mdl_front = ~mdl_front;
        goto(4 + 2 * P + 2 * FRAME);
        push_exp(2);
        got = {led_selc, led_r, led_g, led_b}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL bp_shown got %h required %h", got, want); end
    endtask

    task automatic test_out_of_range();
        do_reset();
        goto(2);
        tests++;
        if (wr_ready !== 1'b1) begin fails++; $display("FAIL oor_ready got %b required 1", wr_ready); end
        do_write(4'd13, 3'd0, 3'b111);
        goto(4);
        pulse_swap();
        goto(FRAME);
        tests++;
        if (swap_ack !== 1'b1) begin fails++; $display("FAIL oor_swap got %b required 1", swap_ack); end
        mdl_front = ~mdl_front;
        for (int c = 0; c < COLS; c++) begin
            goto(4 + c * P + FRAME);
            push_exp(c);
            got = {led_selc, led_r, led_g, led_b}; want = exp_q.pop_front(); tests++;
            if (got !== want) begin fails++; $display("FAIL oor c%0d got %h required %h", c, got, want); end
        end
    endtask

    task automatic test_reset_mid_on();
        do_reset();
        goto(2);
        do_write(4'd7, 3'd3, 3'b111);
        goto(4);
        pulse_swap();
        goto(4 + 7 * P + 3);
        push_exp(7);
        got = {led_selc, led_r, led_g, led_b}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL mid_col7 got %h required %h", got, want); end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({led_selc, led_r, led_g, led_b, led_rst, swap_ack, frame_start, wr_ready} !==
            {12'hFFF, 24'h0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL mid_reset selc=%h rgb=%h/%h/%h rst=%b ack=%b fs=%b rdy=%b required FFF/0/0/0/1/0/0/1",
                     led_selc, led_r, led_g, led_b, led_rst, swap_ack, frame_start, wr_ready);
        end
        mdl_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        goto(4);
        push_exp(0);
        got = {led_selc, led_r, led_g, led_b}; want = exp_q.pop_front(); tests++;
        if (got !== want || frame_start !== 1'b1) begin
            fails++; $display("FAIL mid_restart got %h fs=%b required %h fs=1", got, frame_start, want);
        end
        goto(4 + 7 * P);
        push_exp(7);
        got = {led_selc, led_r, led_g, led_b}; want = exp_q.pop_front(); tests++;
        if (got !== want) begin fails++; $display("FAIL mid_blank_col7 got %h required %h", got, want); end
        goto(FRAME + 1);
        tests++;
        if (swap_ack !== 1'b0) begin fails++; $display("FAIL mid_no_ack got %b required 0", swap_ack); end
    endtask

    initial begin
        test_reset();
        test_write_swap();
        test_isolation();
        test_back_pressure();
        test_out_of_range();
        test_reset_mid_on();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
